// File: rtl/stim_sequencer.sv
// Run controller for one random-stimulus pass: loads LFSR seeds, steps them for a
// programmed number of vectors, delays a check strobe by the DUT latency and counts mismatches.
module stim_sequencer #(
    parameter int CNT_W   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk_dut,
    input  logic             reset_dut,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_num_vectors,
    input  logic [31:0]      i_seed_a,
    input  logic [31:0]      i_seed_b,
    input  logic             i_mismatch,
    output logic             o_lfsr_load,
    output logic [31:0]      o_lfsr_seed_a,
    output logic [31:0]      o_lfsr_seed_b,
    output logic             o_lfsr_en,
    output logic             o_drive_valid,
    output logic             o_check_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_vec_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [31:0]        seed_a_q, seed_a_d;
    logic [31:0]        seed_b_q, seed_b_d;
    logic [LATENCY-1:0] chk_sr_q, chk_sr_d;
    logic [3:0]         drain_q, drain_d;
    logic               drive_valid;
    logic               check_valid;

    assign drive_valid = (state_q == ST_RUN);
    assign check_valid = chk_sr_q[LATENCY-1];

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        vec_d    = vec_q;
        err_d    = err_q;
        seed_a_d = seed_a_q;
        seed_b_d = seed_b_q;
        drain_d  = drain_q;
        // Concatenate then truncate so the shift works for LATENCY == 1 as well.
        chk_sr_d = LATENCY'({chk_sr_q, drive_valid});

        if (check_valid && i_mismatch && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    vec_d = '0;
                    err_d = '0;
                    if (i_num_vectors != '0) begin
                        target_d = i_num_vectors;
                        seed_a_d = i_seed_a;
                        seed_b_d = i_seed_b;
                        state_d  = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                drain_d = '0;
                state_d = i_abort ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                vec_d   = vec_q + 1'b1;
                drain_d = '0;
                if (i_abort || (CNT_W'(vec_q + 1'b1) == target_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Held for LATENCY cycles so the last check lands in the final DRAIN cycle.
                if (drain_q == 4'(LATENCY - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_dut) begin
        if (!reset_dut) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            seed_a_q <= '0;
            seed_b_q <= '0;
            chk_sr_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            seed_a_q <= seed_a_d;
            seed_b_q <= seed_b_d;
            chk_sr_q <= chk_sr_d;
            drain_q  <= drain_d;
        end
    end

    assign o_lfsr_load   = (state_q == ST_LOAD);
    assign o_lfsr_en     = drive_valid;
    assign o_drive_valid = drive_valid;
    assign o_check_valid = check_valid;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);
    assign o_lfsr_seed_a = seed_a_q;
    assign o_lfsr_seed_b = seed_b_q;
    assign o_vec_count   = vec_q;
    assign o_err_count   = err_q;
    assign o_state       = state_q;

endmodule
